// File: rtl/uart_tx_stream.sv
// uart_tx_stream: valid/ready word input, circular FIFO and UART serialiser.
// Parity mode and stop-bit count are latched per frame when the word is popped.
module uart_tx_stream #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUDRATE    = 9600
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          fifo_empty
);
  localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
  localparam int BW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  state_e               state_q;
  logic [BW-1:0]        baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q, head;
  logic                 par_en_q, par_bit_q, stop2_q;
  logic                 tx_q, busy_q, done_q;
  logic                 push, pop, baud_last;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign in_ready   = !fifo_full && !rst;
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];
  assign baud_last  = (baud_q == BW'(DIV - 1));
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Line outputs trail the state by one cycle so all of them stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == STOP) && baud_last &&
                (bit_q == {3'b000, stop2_q});
      case (state_q)
        IDLE:    tx_q <= 1'b1;
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        PARITY:  tx_q <= par_bit_q;
        default: tx_q <= 1'b1;
      endcase
      case (state_q)
        IDLE: begin
          if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PW'(1);
            shift_q   <= head;
            par_en_q  <= (parity_mode == 2'b01) ||
                         (parity_mode == 2'b10);
            par_bit_q <= (^head) ^ (parity_mode == 2'b10);
            stop2_q   <= stop2;
            baud_q    <= '0;
            bit_q     <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == {3'b000, stop2_q}) begin
              bit_q   <= '0;
              state_q <= IDLE;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: frame-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_stream;
  localparam int FD  = 4;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       in_ready, tx, tx_busy, tx_done, fifo_full, fifo_empty;
  logic [2:0] fifo_level;

  uart_tx_stream #(
    .DATA_BITS(8), .FIFO_DEPTH(FD),
    .CLK_FREQ_HZ(1000000), .BAUDRATE(100000)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .parity_mode(parity_mode), .stop2(stop2),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                 nm, act, exp, cyc);
    end
  endtask

  // Reference model: queue of accepted words and the waveform of the
  // current frame, expressed as a list of bits each lasting DIV cycles.
  typedef struct { logic [7:0] d; int acc; } ent_t;
  ent_t q[$];
  bit   active = 0;
  int   fs = 0, fl = 0, next_free = 0;
  bit   fbits[12];
  bit   rdy, in_frame;

  function automatic void build_frame(input logic [7:0] d,
                                      input logic [1:0] pm,
                                      input logic st2);
    int n = 0;
    fbits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[n++] = d[i];
    if (pm == 2'b01) fbits[n++] = ^d;
    else if (pm == 2'b10) fbits[n++] = ~^d;
    fbits[n++] = 1'b1;
    if (st2) fbits[n++] = 1'b1;
    fl = n * DIV;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      active = 0;
      next_free = 0;
    end else begin
      rdy = (q.size() < FD);
      if (q.size() > 0 && q[0].acc < cyc && cyc >= next_free) begin
        build_frame(q[0].d, parity_mode, stop2);
        fs = cyc + 1;
        next_free = fs + fl;
        active = 1;
        void'(q.pop_front());
      end
      if (in_valid && rdy) q.push_back('{d: in_data, acc: cyc});
    end
    #1;
    in_frame = active && cyc >= fs && cyc < fs + fl;
    chk("tx", tx, in_frame ? fbits[(cyc - fs) / DIV] : 1'b1);
    chk("tx_busy", tx_busy, in_frame);
    chk("tx_done", tx_done, in_frame && cyc == fs + fl - 1);
    chk("fifo_level", fifo_level, q.size());
    chk("fifo_full", fifo_full, q.size() == FD);
    chk("fifo_empty", fifo_empty, q.size() == 0);
    chk("in_ready", in_ready, !rst && q.size() < FD);
  end

  logic cap_tx[260];
  int   cap_busy, cap_done, cap_done_at;

  task automatic capture(input int n);
    cap_busy = 0;
    cap_done = 0;
    cap_done_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #2;
      cap_tx[i] = tx;
      cap_busy += int'(tx_busy);
      if (tx_done) begin
        cap_done++;
        cap_done_at = i;
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input bit keep);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((q.size() > 0 || cyc <= next_free) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 4000) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic lit_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit   acc_last;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // 8N1 frame of 0xA5
    push(8'hA5, 0);
    capture(105);
    chk("a5_idle_k1", cap_tx[1], 1);
    chk("a5_start_k2", cap_tx[2], 0);
    chk("a5_start_end", cap_tx[11], 0);
    for (int b = 0; b < 8; b++)
      chk("a5_bit", cap_tx[2 + 10 * (b + 1) + 5], lit_a5[b]);
    chk("a5_stop", cap_tx[97], 1);
    chk("a5_len", cap_busy, 100);
    chk("a5_done_cnt", cap_done, 1);
    chk("a5_done_at", cap_done_at, 101);
    drain();

    // even, then odd parity with two stop bits
    parity_mode = 2'b01;
    stop2 = 1'b1;
    push(8'h03, 0);
    capture(125);
    chk("even_par", cap_tx[97], 0);
    chk("even_stop2", cap_tx[120], 1);
    chk("even_len", cap_busy, 120);
    drain();
    parity_mode = 2'b10;
    push(8'h03, 0);
    capture(125);
    chk("odd_par", cap_tx[97], 1);
    chk("odd_len", cap_busy, 120);
    chk("odd_done", cap_done, 1);
    drain();

    // burst of 6 with in_valid held; FIFO fills while the line is busy
    parity_mode = 2'b00;
    stop2 = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1);
    #1;
    chk("burst_full", fifo_full, 1);
    chk("burst_level", fifo_level, 4);
    chk("burst_ready", in_ready, 0);
    push(8'h15, 0);
    drain();

    // reset in the middle of the first data bits of a 3-word burst
    for (int i = 0; i < 3; i++) push(8'h5A ^ 8'(i), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_done", tx_done, 0);
    @(negedge clk);
    rst = 1'b0;
    capture(150);
    chk("post_rst_done", cap_done, 0);
    chk("post_rst_busy", cap_busy, 0);

    // config change mid-frame affects only the next frame
    push(8'h00, 1);
    push(8'h03, 0);
    fork
      capture(240);
      begin
        repeat (20) @(negedge clk);
        parity_mode = 2'b01;
        stop2 = 1'b1;
      end
    join
    chk("cfg_f1_stop", cap_tx[95], 1);
    chk("cfg_f2_par", cap_tx[197], 0);
    chk("cfg_busy", cap_busy, 220);
    chk("cfg_done", cap_done, 2);
    drain();

    // random traffic, config changes and rare resets
    acc_last = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 3) == 0);
        in_data = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) begin
        parity_mode = 2'($urandom);
        stop2 = 1'($urandom);
      end
      rst = ($urandom_range(0, 1999) == 0);
      acc_last = in_valid && !rst && !fifo_full;
    end
    @(negedge clk);
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
